// File: rtl/lsu_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bank_responder
// Purpose  : Memory-side responder for one LSU port over NUM_BANKS SRAM banks,
//            with a lower-priority host port for preload and readback.
// Revision : 1.0
// ============================================================================

// Read-return pipeline: each stage holds its word until a new valid one arrives,
// so the last stage keeps the most recent return while idle.
module lsu_bank_rd_pipe #(
    parameter int STAGES = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    logic [STAGES-1:0]             vld;
    logic [STAGES-1:0][DATA_W-1:0] dat;
    logic [STAGES:0]               vld_cat;
    logic [STAGES:0][DATA_W-1:0]   dat_cat;

    assign vld_cat = {vld, in_vld};
    assign dat_cat = {dat, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            dat <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                vld[i] <= vld_cat[i];
                if (vld_cat[i]) dat[i] <= dat_cat[i];
            end
        end
    end

    assign out_vld  = vld_cat[STAGES];
    assign out_data = dat_cat[STAGES];
endmodule

module lsu_bank_responder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          R_request,
    input  logic [4+DATA_W-1:0] W_request,
    input  logic [3+ADDR_W-1:0] LSU_addr_bus,
    output logic [DATA_W:0]     CBG_to_LSU_bus,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [2:0]          host_bank,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    output logic                host_ack,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                sel_err
);
    localparam int SEL_W      = 3;
    localparam int BANK_DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [SEL_W-1:0]  r_sel, w_sel, addr_sel;
    logic              ren, wen;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
    logic              rd_acc, wr_acc, lsu_acc, sel_bad, bank_busy;
    logic [1:0]        state, state_next;
    logic              host_go;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
    logic              lsu_vld, host_vld;
    logic [DATA_W-1:0] lsu_dat, host_dat;

    assign {r_sel, ren}        = R_request;
    assign {w_sel, wen, wdata} = W_request;
    assign {addr_sel, addr}    = LSU_addr_bus;

    assign rd_acc    = ren && (r_sel == addr_sel);
    assign wr_acc    = wen && (w_sel == addr_sel);
    assign lsu_acc   = rd_acc || wr_acc;
    assign sel_bad   = (ren && (r_sel != addr_sel)) || (wen && (w_sel != addr_sel));
    assign bank_busy = lsu_acc && (addr_sel == host_bank);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_WAIT: begin
                if (!host_req)      state_next = ST_IDLE;
                else if (bank_busy) state_next = ST_WAIT;
                else                state_next = ST_ACK;
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The host touches its bank on the cycle it is granted; host_ack follows.
    always_comb begin
        host_go = 1'b0;
        if ((state == ST_IDLE || state == ST_WAIT) && host_req && !bank_busy)
            host_go = 1'b1;
    end

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [DATA_W-1:0] mem [BANK_DEPTH];
            logic              lsu_hit, host_hit, port_we;
            logic [ADDR_W-1:0] port_addr;
            logic [DATA_W-1:0] port_wdata;

            assign lsu_hit    = lsu_acc && (addr_sel == SEL_W'(b));
            assign host_hit   = host_go && (host_bank == SEL_W'(b));
            assign port_addr  = lsu_hit ? addr : host_addr;
            assign port_we    = lsu_hit ? wr_acc : (host_hit && host_we);
            assign port_wdata = lsu_hit ? wdata : host_wdata;

            always_ff @(posedge clk) begin
                if (port_we) mem[port_addr] <= port_wdata;
            end

            // Read samples the pre-edge contents, giving read-before-write.
            assign bank_rdata[b] = mem[port_addr];
        end
    endgenerate

    lsu_bank_rd_pipe #(.STAGES(RD_LAT), .DATA_W(DATA_W)) u_lsu_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_acc),
        .in_data  (bank_rdata[addr_sel]),
        .out_vld  (lsu_vld),
        .out_data (lsu_dat)
    );

    // One extra stage so host data trails host_ack by RD_LAT cycles.
    lsu_bank_rd_pipe #(.STAGES(RD_LAT + 1), .DATA_W(DATA_W)) u_host_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (host_go && !host_we),
        .in_data  (bank_rdata[host_bank]),
        .out_vld  (host_vld),
        .out_data (host_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_ack <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            host_ack <= (state_next == ST_ACK);
            if (sel_bad) sel_err <= 1'b1;
        end
    end

    assign CBG_to_LSU_bus = {lsu_vld, lsu_dat};
    assign host_rvalid    = host_vld;
    assign host_rdata     = host_dat;
endmodule
`default_nettype wire

// File: tb/tb_lsu_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bank_responder
// Purpose  : Directed + randomized self-checking bench with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_lsu_bank_responder;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ren, wen;
    logic [2:0]        r_sel, w_sel, a_sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              h_req, h_we;
    logic [2:0]        h_bank;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;

    logic [3:0]          r_request;
    logic [4+DATA_W-1:0] w_request;
    logic [3+ADDR_W-1:0] addr_bus;
    logic [DATA_W:0]     bus;
    logic                host_ack, host_rvalid, sel_err;
    logic [DATA_W-1:0]   host_rdata;

    assign r_request = {r_sel, ren};
    assign w_request = {w_sel, wen, wdata};
    assign addr_bus  = {a_sel, addr};

    lsu_bank_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(8), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .R_request      (r_request),
        .W_request      (w_request),
        .LSU_addr_bus   (addr_bus),
        .CBG_to_LSU_bus (bus),
        .host_req       (h_req),
        .host_we        (h_we),
        .host_bank      (h_bank),
        .host_addr      (h_addr),
        .host_wdata     (h_wdata),
        .host_ack       (host_ack),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .sel_err        (sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] mm [8][1024];
    rd_t         lq[$];
    rd_t         hq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        e_vld, e_ack, e_hv, e_err;
    logic [31:0] e_data, e_hd;

    task automatic model_reset();
        lq.delete();
        hq.delete();
        e_vld = 0; e_data = 0; e_ack = 0; e_hv = 0; e_hd = 0; e_err = 0;
    endtask

    // Applies one clock edge's worth of the LSU/host rules to the model.
    task automatic model_edge();
        bit rd_ok, wr_ok, grant;
        rd_t r;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        rd_ok = ren && (r_sel == a_sel);
        wr_ok = wen && (w_sel == a_sel);
        if ((ren && r_sel != a_sel) || (wen && w_sel != a_sel)) e_err = 1;
        grant = h_req && !e_ack && !((rd_ok || wr_ok) && a_sel == h_bank);
        if (rd_ok) begin
            r.due = cyc + RD_LAT - 1; r.d = mm[a_sel][addr]; lq.push_back(r);
        end
        if (grant && !h_we) begin
            r.due = cyc + RD_LAT; r.d = mm[h_bank][h_addr]; hq.push_back(r);
        end
        if (wr_ok) mm[a_sel][addr] = wdata;
        if (grant && h_we) mm[h_bank][h_addr] = h_wdata;
        e_ack = grant;
        e_vld = 0;
        if (lq.size() > 0 && lq[0].due == cyc) begin
            e_vld = 1; e_data = lq[0].d; void'(lq.pop_front());
        end
        e_hv = 0;
        if (hq.size() > 0 && hq[0].due == cyc) begin
            e_hv = 1; e_hd = hq[0].d; void'(hq.pop_front());
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        check("lsu_bus", 64'(bus), 64'({e_vld, e_data}));
        check("host_ack", 64'(host_ack), 64'(e_ack));
        check("host_rvalid", 64'(host_rvalid), 64'(e_hv));
        check("host_rdata", 64'(host_rdata), 64'(e_hd));
        check("sel_err", 64'(sel_err), 64'(e_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_lsu(input logic re, input logic [2:0] rs, input logic we, input logic [2:0] ws,
                           input logic [2:0] as, input logic [ADDR_W-1:0] ad, input logic [31:0] wd);
        ren = re; r_sel = rs; wen = we; w_sel = ws; a_sel = as; addr = ad; wdata = wd;
    endtask

    task automatic host_op(input logic we, input logic [2:0] bk, input logic [ADDR_W-1:0] ad,
                           input logic [31:0] wd);
        bit got;
        got = 0;
        h_req = 1; h_we = we; h_bank = bk; h_addr = ad; h_wdata = wd;
        for (int i = 0; i < 64 && !got; i++) begin
            step();
            got = host_ack;
        end
        h_req = 0;
        check("host_op_ack", 64'(got), 64'd1);
        if (!we) repeat (RD_LAT) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nv;
        int k;
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        h_req = 0; h_we = 0; h_bank = 0; h_addr = 0; h_wdata = 0;
        model_reset();
        rst = 1;
        step();
        step();
        rst = 0;

        // Preload every bank, addresses 0..15, with random words.
        for (int bk = 0; bk < 8; bk++)
            for (int a = 0; a < 16; a++)
                host_op(1, 3'(bk), ADDR_W'(a), $urandom());

        // Host preload + readback, then LSU read with RD_LAT latency.
        host_op(1, 3, 5, 32'hDEADBEEF);
        host_op(0, 3, 5, 0);
        check("host_readback_b3a5", 64'(host_rdata), 64'h0DEADBEEF);
        set_lsu(1, 3, 0, 0, 3, 5, 0);
        step();
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        check("lsu_b3a5_not_yet", 64'(bus[DATA_W]), 64'd0);
        step();
        check("lsu_b3a5_read", 64'(bus), {31'd0, 1'b1, 32'hDEADBEEF});

        // Back-to-back reads of bank 1 preloaded with i*4.
        for (int i = 0; i < 8; i++) host_op(1, 1, ADDR_W'(i), 32'(i * 4));
        nv = 0;
        k = 0;
        for (int i = 0; i < 8 + RD_LAT; i++) begin
            if (i < 8) set_lsu(1, 1, 0, 0, 1, ADDR_W'(i), 0);
            else       set_lsu(0, 0, 0, 0, 0, 0, 0);
            step();
            if (bus[DATA_W]) begin
                nv++;
                check("b2b_data", 64'(bus[DATA_W-1:0]), 64'(k * 4));
                k++;
            end
        end
        check("b2b_valid_count", 64'(nv), 64'd8);

        // Same-bank read+write: old data first, new data after.
        host_op(1, 2, 9, 32'h11);
        set_lsu(1, 2, 1, 2, 2, 9, 32'h22);
        step();
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        step();
        check("rw_same_old", 64'(bus), {31'd0, 1'b1, 32'h11});
        set_lsu(1, 2, 0, 0, 2, 9, 0);
        step();
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        step();
        check("rw_same_new", 64'(bus), {31'd0, 1'b1, 32'h22});

        // Host write to bank 0 held off while the LSU streams bank 0.
        h_req = 1; h_we = 1; h_bank = 0; h_addr = 100; h_wdata = 32'hCAFE0001;
        for (int i = 0; i < 6; i++) begin
            set_lsu(1, 0, 0, 0, 0, ADDR_W'(i), 0);
            step();
            check("host_held_off", 64'(host_ack), 64'd0);
        end
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        step();
        check("host_ack_after_stream", 64'(host_ack), 64'd1);
        h_req = 0;
        repeat (RD_LAT) step();
        set_lsu(1, 0, 0, 0, 0, 100, 0);
        step();
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        step();
        check("host_write_landed", 64'(bus), {31'd0, 1'b1, 32'hCAFE0001});

        // Selector mismatch: dropped, sticky error.
        check("sel_err_clear", 64'(sel_err), 64'd0);
        set_lsu(1, 4, 0, 0, 5, 7, 0);
        step();
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        nv = 0;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            step();
            if (bus[DATA_W]) nv++;
        end
        check("sel_err_no_valid", 64'(nv), 64'd0);
        check("sel_err_set", 64'(sel_err), 64'd1);

        // ren/wen to different banks: only the addr_sel match survives.
        host_op(1, 6, 9, 32'h66);
        set_lsu(1, 2, 1, 6, 2, 9, 32'h77);
        step();
        set_lsu(1, 6, 0, 0, 6, 9, 0);
        step();
        check("diff_bank_read", 64'(bus), {31'd0, 1'b1, 32'h22});
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        step();
        check("diff_bank_write_dropped", 64'(bus), {31'd0, 1'b1, 32'h66});

        // Randomized LSU traffic with concurrent host requests.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] as;
            as = 3'($urandom_range(0, 7));
            set_lsu(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0) ? as : 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0) ? as : 3'($urandom_range(0, 7)),
                    as, ADDR_W'($urandom_range(0, 15)), $urandom());
            if (!h_req && $urandom_range(0, 3) == 0) begin
                h_req = 1;
                h_we = 1'($urandom_range(0, 1));
                h_bank = 3'($urandom_range(0, 7));
                h_addr = ADDR_W'($urandom_range(0, 15));
                h_wdata = $urandom();
            end
            step();
            if (host_ack) h_req = 0;
        end
        h_req = 0;
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        repeat (RD_LAT + 2) step();

        // Asynchronous reset with a read in flight.
        set_lsu(1, 1, 0, 0, 1, 3, 0);
        step();
        #2;
        rst = 1;
        model_reset();
        #1;
        check_outputs();
        check("reset_sel_err", 64'(sel_err), 64'd0);
        step();
        rst = 0;
        set_lsu(0, 0, 0, 0, 0, 0, 0);
        nv = 0;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            step();
            if (bus[DATA_W]) nv++;
        end
        check("no_valid_after_reset", 64'(nv), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
